// File: rtl/led_chase_monitor_if.sv
// led_chase_monitor_if: LED chaser bus plus the monitor's status outputs.
interface led_chase_monitor_if #(parameter int COUNT_W = 16);
  logic [3:0] LEDS;
  logic Clear, Valid, Dir, DirFlip, Error, Stalled;
  logic [1:0] Position, ErrCode;
  logic [COUNT_W-1:0] StepCount;
  modport master (
    output LEDS, Clear,
    input Valid, Position, Dir, DirFlip, StepCount, Error, ErrCode, Stalled
  );
  modport slave (
    input LEDS, Clear,
    output Valid, Position, Dir, DirFlip, StepCount, Error, ErrCode, Stalled
  );
endinterface

// File: rtl/led_chase_monitor.sv
// led_chase_monitor: one-hot LED chaser checker (position, direction, steps, sticky error).
// Optional stall detector enabled by LED_CHASE_MONITOR_STALL_EN.
module led_chase_monitor #(
  parameter int COUNT_W = 16
`ifdef LED_CHASE_MONITOR_STALL_EN
  , parameter int STALL_CYCLES = 100000000
`endif
) (
  input logic Clk,
  input logic Reset_n,
  led_chase_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_e;
  state_e state_q, state_d;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic valid_q, valid_d, dir_q, dir_d, flip_q, flip_d, err_q, err_d, have_q, have_d;
  logic [1:0] pos_q, pos_d, code_q, code_d, s_pos, p_pos, delta;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic one_hot, same;
  assign one_hot = sync2_q inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  assign same = sync2_q == prev_q;
  assign s_pos = {sync2_q[3] | sync2_q[2], sync2_q[3] | sync2_q[1]};
  assign p_pos = {prev_q[3] | prev_q[2], prev_q[3] | prev_q[1]};
  assign delta = s_pos - p_pos;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pos_d = pos_q;
    dir_d = dir_q;
    flip_d = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    code_d = code_q;
    have_d = have_q;
    if (bus.Clear) begin
      state_d = IDLE;
      valid_d = 1'b0;
      err_d = 1'b0;
      code_d = 2'b00;
      cnt_d = '0;
      have_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (one_hot) begin
        state_d = TRACK;
        valid_d = 1'b1;
        pos_d = s_pos;
      end
    end else if (state_q == TRACK) begin
      if (!same && !one_hot) begin
        state_d = FAULT;
        valid_d = 1'b0;
        err_d = 1'b1;
        code_d = 2'b01;
      end else if (!same) begin
        pos_d = s_pos;
        // delta 1 is ascending, 3 descending (mod-4 wrap), 2 a skipped LED
        if (delta == 2'd2) begin
          state_d = FAULT;
          err_d = 1'b1;
          code_d = 2'b10;
        end else begin
          dir_d = delta == 2'd1;
          flip_d = have_q && ((delta == 2'd1) != dir_q);
          have_d = 1'b1;
          cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end
      end
    end else begin
      valid_d = one_hot;
      pos_d = one_hot ? s_pos : pos_q;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q <= '0;
      valid_q <= 1'b0;
      pos_q <= 2'd0;
      dir_q <= 1'b1;
      flip_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      code_q <= 2'b00;
      have_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.LEDS;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      valid_q <= valid_d;
      pos_q <= pos_d;
      dir_q <= dir_d;
      flip_q <= flip_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      code_q <= code_d;
      have_q <= have_d;
    end
  end
  assign bus.Valid = valid_q;
  assign bus.Position = pos_q;
  assign bus.Dir = dir_q;
  assign bus.DirFlip = flip_q;
  assign bus.StepCount = cnt_q;
  assign bus.Error = err_q;
  assign bus.ErrCode = code_q;
`ifdef LED_CHASE_MONITOR_STALL_EN
  localparam int SW = $clog2(STALL_CYCLES);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES - 1);
  logic [SW-1:0] stall_q, stall_d;
  logic stalled_q, stalled_d, hold;
  assign hold = !bus.Clear && state_q == TRACK && same;
  always_comb begin
    stall_d = hold ? (stall_q == STALL_MAX ? stall_q : stall_q + 1'b1) : '0;
    stalled_d = hold && stall_q == STALL_MAX;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      stall_q <= '0;
      stalled_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      stalled_q <= stalled_d;
    end
  end
  assign bus.Stalled = stalled_q;
`else
  assign bus.Stalled = 1'b0;
`endif
endmodule

// File: tb/tb_led_chase_monitor.sv
// tb_led_chase_monitor: directed vector table plus hand sequences for latency, clear, reset and stall.
module tb_led_chase_monitor;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errs = 0;
  int flips = 0;
  always #5 clk = ~clk;
  led_chase_monitor_if #(.COUNT_W(16)) bus ();
`ifdef LED_CHASE_MONITOR_STALL_EN
  localparam int STALL_EN = 1;
  led_chase_monitor #(.COUNT_W(16), .STALL_CYCLES(16)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
`else
  localparam int STALL_EN = 0;
  led_chase_monitor #(.COUNT_W(16)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
`endif
  always @(negedge clk) if (bus.DirFlip) flips++;
  typedef struct {
    logic [3:0] leds;
    logic clr;
    int cyc;
    int v, p, d, c, e, code, f;
  } vec_t;
  vec_t tbl[19];
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input int v, input int p, input int d, input int c, input int e, input int code);
    chk({tag, ".Valid"}, int'(bus.Valid), v);
    chk({tag, ".Position"}, int'(bus.Position), p);
    chk({tag, ".Dir"}, int'(bus.Dir), d);
    chk({tag, ".StepCount"}, int'(bus.StepCount), c);
    chk({tag, ".Error"}, int'(bus.Error), e);
    chk({tag, ".ErrCode"}, int'(bus.ErrCode), code);
  endtask
  initial begin
    tbl[0]  = '{4'b0010, 1'b0, 20, 1, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{4'b0100, 1'b0, 20, 1, 2, 1, 2, 0, 0, 0};
    tbl[2]  = '{4'b1000, 1'b0, 20, 1, 3, 1, 3, 0, 0, 0};
    tbl[3]  = '{4'b0001, 1'b0, 20, 1, 0, 1, 4, 0, 0, 0};
    tbl[4]  = '{4'b0010, 1'b0, 20, 1, 1, 1, 5, 0, 0, 0};
    tbl[5]  = '{4'b0001, 1'b0, 20, 1, 0, 0, 6, 0, 0, 1};
    tbl[6]  = '{4'b1000, 1'b0, 20, 1, 3, 0, 7, 0, 0, 1};
    tbl[7]  = '{4'b0100, 1'b0, 20, 1, 2, 0, 8, 0, 0, 1};
    tbl[8]  = '{4'b0010, 1'b0, 20, 1, 1, 0, 9, 0, 0, 1};
    tbl[9]  = '{4'b0100, 1'b0, 20, 1, 2, 1, 10, 0, 0, 2};
    tbl[10] = '{4'b0100, 1'b1, 20, 1, 2, 1, 0, 0, 0, 2};
    tbl[11] = '{4'b0010, 1'b0, 20, 1, 1, 0, 1, 0, 0, 2};
    tbl[12] = '{4'b1000, 1'b0, 20, 1, 3, 0, 1, 1, 2, 2};
    tbl[13] = '{4'b0110, 1'b0, 20, 0, 3, 0, 1, 1, 2, 2};
    tbl[14] = '{4'b0001, 1'b0, 20, 1, 0, 0, 1, 1, 2, 2};
    tbl[15] = '{4'b0001, 1'b1, 20, 1, 0, 0, 0, 0, 0, 2};
    tbl[16] = '{4'b0011, 1'b0, 20, 0, 0, 0, 0, 1, 1, 2};
    tbl[17] = '{4'b0011, 1'b1, 20, 0, 0, 0, 0, 0, 0, 2};
    tbl[18] = '{4'b0100, 1'b0, 20, 1, 2, 0, 0, 0, 0, 2};
    rst_n = 1'b0;
    bus.LEDS = 4'b0000;
    bus.Clear = 1'b0;
    tick(3);
    chk_all("reset", 0, 0, 1, 0, 0, 0);
    chk("reset.Stalled", int'(bus.Stalled), 0);
    rst_n = 1'b1;
    tick(10);
    chk_all("idle_zero", 0, 0, 1, 0, 0, 0);
    bus.LEDS = 4'b0001;
    tick(2);
    chk("latency2.Valid", int'(bus.Valid), 0);
    tick(1);
    chk_all("latency3", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      bus.LEDS = tbl[i].leds;
      bus.Clear = tbl[i].clr;
      if (tbl[i].clr) begin
        tick(1);
        bus.Clear = 1'b0;
      end
      tick(tbl[i].cyc);
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].c, tbl[i].e, tbl[i].code);
      chk($sformatf("vec%0d.flips", i), flips, tbl[i].f);
    end
    bus.LEDS = 4'b0011;
    tick(2);
    bus.Clear = 1'b1;
    tick(1);
    bus.Clear = 1'b0;
    chk("clr_race.Error", int'(bus.Error), 0);
    chk("clr_race.Valid", int'(bus.Valid), 0);
    tick(5);
    chk("clr_race_idle.Error", int'(bus.Error), 0);
    chk("clr_race_idle.ErrCode", int'(bus.ErrCode), 0);
    bus.LEDS = 4'b0001;
    tick(5);
    chk_all("reacq", 1, 0, 0, 0, 0, 0);
    bus.LEDS = 4'b0010;
    tick(5);
    chk_all("post_clear_step", 1, 1, 1, 1, 0, 0);
    chk("post_clear_step.flips", flips, 2);
    rst_n = 1'b0;
    tick(1);
    chk_all("mid_reset", 0, 0, 1, 0, 0, 0);
    chk("mid_reset.DirFlip", int'(bus.DirFlip), 0);
    chk("mid_reset.Stalled", int'(bus.Stalled), 0);
    rst_n = 1'b1;
    bus.LEDS = 4'b0100;
    tick(18);
    chk("stall_pre.Stalled", int'(bus.Stalled), 0);
    chk_all("stall_hold", 1, 2, 1, 0, 0, 0);
    tick(1);
    chk("stall_on.Stalled", int'(bus.Stalled), STALL_EN);
    tick(3);
    chk("stall_keep.Stalled", int'(bus.Stalled), STALL_EN);
    bus.LEDS = 4'b1000;
    tick(2);
    chk("stall_pipe.Stalled", int'(bus.Stalled), STALL_EN);
    tick(1);
    chk("stall_off.Stalled", int'(bus.Stalled), 0);
    chk_all("stall_step", 1, 3, 1, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule

// File: doc/led_chase_monitor.md
Name: led_chase_monitor

Overview:
- Reader side of the 4-bit one-hot LED chaser bus.
- Samples LEDS in the Clk domain, decodes the lit position and the chase direction, and counts legal steps.
- Flags illegal patterns and non-adjacent jumps with a sticky error, and flags a stalled chase.
- Sits beside the chaser on the board as a self-check and status source; it never drives LEDS.

Parameters:
- COUNT_W, 16, width of StepCount.
- STALL_CYCLES, 100000000, Clk cycles without a pattern change before Stalled asserts (2 s at 50 MHz).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- LEDS  input  4  chaser LED bus, one-hot in normal operation; asynchronous to Clk.
- Clear  input  1  synchronous pulse; clears error state and counters.
- Valid  output  1  current sampled pattern is one-hot.
- Position  output  2  index of the lit LED: 1→0, 2→1, 4→2, 8→3.
- Dir  output  1  last legal step direction; 1 = ascending (1→2→4→8→1), 0 = descending.
- DirFlip  output  1  one-cycle pulse when a legal step reverses Dir.
- StepCount  output  COUNT_W  legal steps since reset or Clear; saturating.
- Error  output  1  sticky fault flag.
- ErrCode  output  2  first fault: 00 none, 01 illegal pattern, 10 non-adjacent jump, 11 reserved.
- Stalled  output  1  pattern unchanged for STALL_CYCLES in TRACK.

Behaviour:
- One clock, Clk. Reset is synchronous and active-low.
- Reset (Reset_n=0 at a Clk edge) sets: Valid=0, Position=0, Dir=1, DirFlip=0, StepCount=0, Error=0, ErrCode=00, Stalled=0, sync flops=0, prev pattern=0, state=IDLE, HaveDir=0. Reset mid-chase gives these values at the next edge.
- Input path: 2-flop synchronizer, then a prev-pattern register.
- Latency: a change on LEDS is reflected on the outputs after the 3rd rising Clk edge.
- Step classification (on the synchronized pattern S vs prev P, both one-hot):
  - pos(S) = pos(P)+1 mod 4 → ascending.
  - pos(S) = pos(P)−1 mod 4 → descending.
  - distance 2 → jump.
  - Wrap 8→1 is ascending; 1→8 is descending.
- IDLE state:
  - Valid=0.
  - Non-one-hot S (including 0000) is ignored, no error.
  - First one-hot S → TRACK, Valid=1, Position=pos(S). No step counted.
- TRACK state:
  - S==P: no action; stall counter increments.
  - Adjacent step: Position and Dir updated; StepCount+1, saturating at all-ones. DirFlip=1 for one cycle if HaveDir=1 and the new Dir differs from the old Dir. HaveDir is set to 1.
  - Jump: Position updated, Valid=1, Error=1, ErrCode=10 → FAULT.
  - Non-one-hot: Valid=0, Position held, Error=1, ErrCode=01 → FAULT.
- FAULT state:
  - Valid/Position keep tracking S.
  - StepCount frozen; DirFlip held 0.
  - ErrCode holds the first fault; later faults do not overwrite it.
  - Exit only via Clear or reset.
- Clear: next edge sets Error=0, ErrCode=00, StepCount=0, HaveDir=0, Stalled=0, state=IDLE, Valid=0.
  - Clear has priority over any same-cycle step or fault; that event is discarded.
  - Re-acquisition occurs on the next differing-or-equal one-hot S.
- Stall counter: cleared on any S≠P, in IDLE/FAULT, and on Clear. In TRACK it counts S==P cycles, saturating. Stalled=1 when the count reaches STALL_CYCLES−1; Stalled clears on the edge where S≠P.

Optional Feature:
- Macro: LED_CHASE_MONITOR_STALL_EN.
- Defined: stall counter (width clog2(STALL_CYCLES)) and Stalled are implemented as above.
- Undefined: no counter is instantiated; Stalled is tied to 0; all other behaviour is unchanged.

Test Plan:
- Reset, LEDS=0000 for 10 cycles, then LEDS=0001 → Valid=1, Position=0, StepCount=0, Error=0, 3 cycles after the change.
- Ascending sequence 1,2,4,8,1,2, held 20 cycles each → StepCount=5, Dir=1, Position=1, DirFlip never high.
- From 8 step descending 8→4→2, then ascending 2→4 → exactly one DirFlip pulse (on 2→4), StepCount=3, Dir=1.
- From 0010 apply 1000, then later 0110 → Error=1, ErrCode=10 (not 01), Valid=0 after 0110. Then pulse Clear with LEDS=0001 → IDLE then TRACK, Position=0, StepCount=0, Error=0.
- STALL_EN, STALL_CYCLES=16: hold 0100 in TRACK → Stalled=1 exactly 16 edges after entering the hold count; change to 1000 → Stalled=0, StepCount+1.
- Assert Clear in the same cycle a 0011 pattern is classified → Error stays 0, state IDLE. Assert Reset_n=0 mid-chase → all outputs at reset values at the next edge.
